input_unit: RTL
===============

INPUT_UNIT -- requirements
Module: input_unit

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in flits; a power of two.
REQ-002 Parameter WIDTH, default 3, pointer width, log2(DEPTH).
REQ-003 Parameter DATASIZE, default 40, flit width {src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0]}.
REQ-004 Parameter LOCAL_X, default 0, 2-bit X coordinate of this router.
REQ-005 Parameter LOCAL_Y, default 0, 2-bit Y coordinate of this router.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 data_in  input  DATASIZE  flit from the upstream link or the local core.
REQ-009 valid_in  input  1  data_in carries a flit this cycle.
REQ-010 full  output  1  FIFO holds DEPTH flits; the upstream source holds its flit.
REQ-011 label  output  4  route request to the switch allocator: {W,N,E,S}; 4'b0000 = local; 4'b1111 = no flit.
REQ-012 data_out  output  DATASIZE  head flit, valid only while label != 4'b1111.
REQ-013 ready  input  1  allocator ready for this port; the head flit is consumed this cycle.
REQ-014 count  output  WIDTH+1  current FIFO occupancy.

Function
REQ-015 Node id: dst[1:0] = X, dst[3:2] = Y.
REQ-016 XY routing is computed once, at write time; the 4-bit label is stored in the FIFO alongside each flit.
REQ-017 Routing: dst X > LOCAL_X -> 4'b0010 (E); dst X < LOCAL_X -> 4'b1000 (W); X equal and dst Y > LOCAL_Y -> 4'b0100 (N); X equal and dst Y < LOCAL_Y -> 4'b0001 (S); both equal -> 4'b0000 (local).
REQ-018 The FIFO is first-word-fall-through: data_out and label are driven combinationally from the head entry.
REQ-019 When empty: label = 4'b1111 and data_out = 0.
REQ-020 Push condition: valid_in && !full.
- With valid_in && full, the flit is ignored and state is unchanged.
- full is a decode of the registered count only; there is no same-cycle pass-through on pop.
REQ-021 Pop condition: ready && (count != 0); ready while empty has no effect.
REQ-022 Write-to-head latency is 1 cycle: a flit pushed into an empty FIFO appears on label/data_out in the next cycle.
REQ-023 Simultaneous push and pop: count is unchanged, both pointers advance, and the new entry lands behind the popped head.
REQ-024 Read and write pointers are WIDTH bits wide and wrap modulo DEPTH.
REQ-025 count increments on push only, decrements on pop only, and is held otherwise.
- count never exceeds DEPTH or goes below 0.
REQ-026 full = (count == DEPTH).
REQ-027 Flits leave in strict arrival order.
REQ-028 Flit contents, including timestamp, are not modified.

Reset
REQ-029 While rst is high, asynchronously: pointers = 0, count = 0, full = 0, label = 4'b1111, data_out = 0.
REQ-030 Reset asserted mid-operation discards all stored flits; the first push after rst falls is treated as a push into an empty FIFO.
REQ-031 Storage array contents need not be reset; they are never visible while the FIFO is empty.

Verification
REQ-032 LOCAL_X=1, LOCAL_Y=1; push dst 4'b0111 -> next cycle label=4'b0010, count=1.
REQ-033 Same config; push dst 4'b0101, then dst 4'b0001, then dst 4'b0100, with ready=0 -> head label=4'b0000; after successive pops the labels are 4'b0001, then 4'b1000, then 4'b1111.
REQ-034 Push 8 flits with ready=0 -> full=1, count=8; a ninth push is ignored; one pop -> full=0, count=7; a subsequent push is accepted, and pointers have wrapped correctly after 16 pushes.
REQ-035 Hold count=3, assert valid_in and ready together for 5 cycles -> count stays 3 and output order equals input order.
REQ-036 Empty FIFO with ready=1 and no valid_in -> count stays 0, label stays 4'b1111.
REQ-037 Assert rst with count=5 -> count=0 and label=4'b1111 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/input_unit.sv
// input_unit: router input port. Buffers incoming flits in a first-word-
// fall-through FIFO and tags each flit with an XY route request. The route
// is computed as the flit is written, so the switch allocator sees it
// immediately when the flit reaches the head.
module input_unit #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = 40,
  parameter int LOCAL_X  = 0,
  parameter int LOCAL_Y  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] data_in,
  input  logic                valid_in,
  output logic                full,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  input  logic                ready,
  output logic [WIDTH:0]      count
);

  localparam logic [WIDTH:0] FULL_COUNT = (WIDTH+1)'(DEPTH);
  localparam logic [1:0]     LX         = 2'(LOCAL_X);
  localparam logic [1:0]     LY         = 2'(LOCAL_Y);

  // Route request encodings, {W,N,E,S}
  localparam logic [3:0] ROUTE_W     = 4'b1000;
  localparam logic [3:0] ROUTE_N     = 4'b0100;
  localparam logic [3:0] ROUTE_E     = 4'b0010;
  localparam logic [3:0] ROUTE_S     = 4'b0001;
  localparam logic [3:0] ROUTE_LOCAL = 4'b0000;
  localparam logic [3:0] ROUTE_NONE  = 4'b1111;

  // Flit storage and the route tag stored alongside each flit. Neither is
  // reset: nothing in them is visible while the FIFO is empty.
  logic [DATASIZE-1:0] flit_mem_reg  [DEPTH];
  logic [3:0]          label_mem_reg [DEPTH];

  logic [WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [WIDTH:0]   count_reg,  count_next;

  logic       push;
  logic       pop;
  logic       empty;
  logic [1:0] dst_x;
  logic [1:0] dst_y;
  logic [3:0] route_label;

  // Destination node id lives in the dst field: X in the low bits, Y above.
  assign dst_x = data_in[33:32];
  assign dst_y = data_in[35:34];

  // XY dimension-order routing: resolve X first, then Y.
  always_comb begin
    route_label = ROUTE_LOCAL;
    if (dst_x > LX)
      route_label = ROUTE_E;
    else if (dst_x < LX)
      route_label = ROUTE_W;
    else if (dst_y > LY)
      route_label = ROUTE_N;
    else if (dst_y < LY)
      route_label = ROUTE_S;
  end

  // full only looks at registered occupancy, so a pop never frees a slot
  // for a push in the same cycle when the FIFO is full.
  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);
  assign push  = valid_in && !full;
  assign pop   = ready && !empty;
  assign count = count_reg;

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push)
      wr_ptr_next = wr_ptr_reg + WIDTH'(1);
    if (pop)
      rd_ptr_next = rd_ptr_reg + WIDTH'(1);
    if (push && !pop)
      count_next = count_reg + (WIDTH+1)'(1);
    else if (pop && !push)
      count_next = count_reg - (WIDTH+1)'(1);
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Store the accepted flit and its route tag at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem_reg[wr_ptr_reg]  <= data_in;
      label_mem_reg[wr_ptr_reg] <= route_label;
    end
  end

  // Fall-through head: present the head entry directly, or idle values
  // when nothing is buffered.
  always_comb begin
    label    = ROUTE_NONE;
    data_out = '0;
    if (!empty) begin
      label    = label_mem_reg[rd_ptr_reg];
      data_out = flit_mem_reg[rd_ptr_reg];
    end
  end

endmodule
